// File: rtl/add_serial_arb_pkg.sv
// rtl/add_serial_arb_pkg.sv - shared state encoding and sizing helpers for the serial-adder arbiter
package add_serial_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      START   = 2'd1,
      WAIT    = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   localparam int DEFAULT_N       = 4;
   localparam int DEFAULT_W       = 8;
   localparam int DEFAULT_ADD_LAT = 9;

   // Requester index width; never zero so a 1-bit index exists even for tiny N.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/add_serial_arb_rr_pick.sv
// rtl/add_serial_arb_rr_pick.sv - combinational round-robin picker, first request at or after ptr
module rr_pick
   import add_serial_arb_pkg::*;
#(
   parameter int N  = DEFAULT_N,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] cand;

   // Scan from farthest to nearest so the candidate closest to ptr is written last and wins.
   always_comb begin
      gnt  = '0;
      idx  = '0;
      cand = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (int'(ptr) + k >= N)
            cand = IW'(int'(ptr) + k - N);
         else
            cand = IW'(int'(ptr) + k);
         if (req[cand]) begin
            gnt       = '0;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/add_serial_arb.sv
// rtl/add_serial_arb.sv - round-robin arbiter sequencing N requesters onto one bit-serial adder
module add_serial_arb
   import add_serial_arb_pkg::*;
#(
   parameter int N       = DEFAULT_N,
   parameter int W       = DEFAULT_W,
   parameter int ADD_LAT = DEFAULT_ADD_LAT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] a_in,
   input  logic [N*W-1:0] b_in,
   output logic [N-1:0]   gnt,
   output logic [N-1:0]   rsp_valid,
   output logic [W-1:0]   rsp_sum,
   output logic           busy,
   output logic           add_en,
   output logic [W-1:0]   add_a,
   output logic [W-1:0]   add_b,
   input  logic [W-1:0]   add_out
);

   localparam int IW = idx_width(N);
   localparam int CW = $clog2(ADD_LAT + 1);

   arb_state_t    state;
   arb_state_t    state_nxt;
   logic [IW-1:0] owner;
   logic [IW-1:0] ptr;
   logic [IW-1:0] pick_idx;
   logic [N-1:0]  pick_gnt;
   logic [N-1:0]  owner_oh;
   logic [CW-1:0] cnt;

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req (req),
      .ptr (ptr),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      owner_oh        = '0;
      owner_oh[owner] = 1'b1;
      gnt             = '0;
      rsp_valid       = '0;
      busy            = (state != IDLE);
      case (state)
         IDLE:    if (|pick_gnt) state_nxt = START;
         START:   state_nxt = WAIT;
         WAIT:    if (cnt == '0) state_nxt = RELEASE;
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (state != IDLE)
         gnt = owner_oh;
      if (state == RELEASE)
         rsp_valid = owner_oh;
   end

   // START=01 and RELEASE=11 are the only states with bit 0 set, so add_en is a bare flop output.
   assign add_en = state[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner   <= '0;
         ptr     <= '0;
         cnt     <= '0;
         add_a   <= '0;
         add_b   <= '0;
         rsp_sum <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|pick_gnt) begin
                  owner <= pick_idx;
                  add_a <= a_in[pick_idx*W +: W];
                  add_b <= b_in[pick_idx*W +: W];
                  cnt   <= CW'(ADD_LAT - 1);
               end
            end
            WAIT: begin
               if (cnt == '0)
                  rsp_sum <= add_out;
               else
                  cnt <= cnt - 1'b1;
            end
            RELEASE: begin
               ptr <= (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_add_serial_arb.sv
// tb/tb_add_serial_arb.sv - self-checking bench for add_serial_arb with a behavioural serial adder
module tb_add_serial_arb;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int LAT = 9;
   localparam int TMO = 40;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] a_in;
   logic [N*W-1:0] b_in;
   logic [N-1:0]   gnt;
   logic [N-1:0]   rsp_valid;
   logic [W-1:0]   rsp_sum;
   logic           busy;
   logic           add_en;
   logic [W-1:0]   add_a;
   logic [W-1:0]   add_b;
   logic [W-1:0]   add_out;

   int checks = 0;
   int errors = 0;
   int model_ptr = 0;
   int exp_rsp = 0;

   add_serial_arb #(
      .N       (N),
      .W       (W),
      .ADD_LAT (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_sum   (rsp_sum),
      .busy      (busy),
      .add_en    (add_en),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_out   (add_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Serial adder: one sum bit per cycle after the load edge, DONE until the next en.
   int         a_st = 0;
   int         a_bits = 0;
   logic [W:0] a_sum = '0;
   int         adder_err = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         a_st    <= 0;
         a_bits  <= 0;
         a_sum   <= '0;
         add_out <= '0;
      end else begin
         case (a_st)
            0: if (add_en) begin
               a_sum   <= add_a + add_b;
               a_bits  <= 0;
               add_out <= '0;
               a_st    <= 1;
            end
            1: begin
               add_out <= W'(int'(a_sum) & ((1 << (a_bits + 1)) - 1));
               a_bits  <= a_bits + 1;
               if (a_bits + 1 == W) a_st <= 2;
               if (add_en) adder_err <= adder_err + 1;
            end
            default: if (add_en) a_st <= 0;
         endcase
      end
   end

   // Protocol observer; its tallies are judged in test_protocol.
   int         mon_err = 0;
   int         en_run = 0;
   int         en_total = 0;
   int         rsp_cnt = 0;
   logic       prev_en = 1'b0;
   logic [N-1:0] prev_gnt = '0;
   logic [W-1:0] prev_a = '0;
   logic [W-1:0] prev_b = '0;

   always @(negedge clk) begin
      if (rst) begin
         en_run   <= 0;
         prev_en  <= 1'b0;
         prev_gnt <= '0;
      end else begin
         mon_err <= mon_err + int'(!$onehot0(gnt)) + int'(busy !== (gnt != '0))
                    + int'(add_en && prev_en)
                    + int'(gnt != '0 && gnt == prev_gnt && (add_a !== prev_a || add_b !== prev_b))
                    + int'(rsp_valid != '0 && (rsp_valid !== gnt || en_run + int'(add_en) != 2));
         en_run   <= (rsp_valid != '0) ? 0 : en_run + int'(add_en);
         en_total <= en_total + int'(add_en);
         rsp_cnt  <= rsp_cnt + int'(rsp_valid != '0);
         prev_en  <= add_en;
         prev_gnt <= gnt;
         prev_a   <= add_a;
         prev_b   <= add_b;
      end
   end

   task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      a_in[i*W +: W] = a;
      b_in[i*W +: W] = b;
   endtask

   task automatic wait_rsp(output int n, output logic [N-1:0] vld, output logic [W-1:0] sum);
      n   = 0;
      vld = '0;
      sum = '0;
      while (n < TMO && vld == '0) begin
         @(posedge clk);
         #1;
         n++;
         if (rsp_valid != '0) begin
            vld = rsp_valid;
            sum = rsp_sum;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt got %b want 0", gnt); end
      checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      checks++; if (rsp_sum !== '0) begin errors++; $display("FAIL reset_rsp_sum got %h want 0", rsp_sum); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (add_en !== 1'b0) begin errors++; $display("FAIL reset_add_en got %b want 0", add_en); end
      checks++; if (add_a !== '0 || add_b !== '0) begin errors++; $display("FAIL reset_add_ab got %h/%h want 0/0", add_a, add_b); end
      @(negedge clk);
      rst = 1'b0;
      model_ptr = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      int           n;
      logic [N-1:0] vld;
      logic [W-1:0] sum;
      logic         en1;
      logic [N-1:0] g1;
      logic [W-1:0] a1;
      logic [W-1:0] b1;
      en1 = 1'b0; g1 = '0; a1 = '0; b1 = '0;
      set_ops(0, 8'h05, 8'h03);
      req = 4'b0001;
      n = 0; vld = '0; sum = '0;
      while (n < TMO && vld == '0) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) begin en1 = add_en; g1 = gnt; a1 = add_a; b1 = add_b; end
         if (rsp_valid != '0) begin vld = rsp_valid; sum = rsp_sum; end
      end
      exp_rsp++;
      checks++; if (en1 !== 1'b1) begin errors++; $display("FAIL single_start_en got %b want 1", en1); end
      checks++; if (g1 !== 4'b0001) begin errors++; $display("FAIL single_start_gnt got %b want 0001", g1); end
      checks++; if (a1 !== 8'h05 || b1 !== 8'h03) begin errors++; $display("FAIL single_operands got %h/%h want 05/03", a1, b1); end
      checks++; if (n !== LAT + 2) begin errors++; $display("FAIL single_latency got %0d want %0d", n, LAT + 2); end
      checks++; if (vld !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid got %b want 0001", vld); end
      checks++; if (sum !== 8'h08) begin errors++; $display("FAIL single_sum got %h want 08", sum); end
      req = '0;
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b want 0", busy); end
      model_ptr = 1;
   endtask

   task automatic test_overflow();
      logic [W-1:0] av [2];
      logic [W-1:0] bv [2];
      logic [W-1:0] ev [2];
      int           n;
      logic [N-1:0] vld;
      logic [W-1:0] sum;
      av = '{8'hFF, 8'hA5};
      bv = '{8'h01, 8'h5A};
      ev = '{8'h00, 8'hFF};
      for (int i = 0; i < 2; i++) begin
         set_ops(2, av[i], bv[i]);
         req = 4'b0100;
         wait_rsp(n, vld, sum);
         exp_rsp++;
         checks++; if (vld !== 4'b0100) begin errors++; $display("FAIL overflow_valid[%0d] got %b want 0100", i, vld); end
         checks++; if (sum !== ev[i]) begin errors++; $display("FAIL overflow_sum[%0d] got %h want %h", i, sum, ev[i]); end
         req = '0;
         @(posedge clk);
         #1;
      end
      model_ptr = 3;
   endtask

   task automatic test_fairness();
      logic [W-1:0] ta [N];
      logic [W-1:0] tb [N];
      logic [W-1:0] es;
      int           n;
      logic [N-1:0] vld;
      logic [W-1:0] sum;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_ptr = 0;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         ta[i] = W'($urandom);
         tb[i] = W'($urandom);
         set_ops(i, ta[i], tb[i]);
      end
      req = 4'b1111;
      for (int k = 0; k < N; k++) begin
         wait_rsp(n, vld, sum);
         exp_rsp++;
         es = ta[k] + tb[k];
         checks++; if (vld !== N'(1 << k)) begin errors++; $display("FAIL fair_order[%0d] got %b want %b", k, vld, N'(1 << k)); end
         checks++; if (sum !== es) begin errors++; $display("FAIL fair_sum[%0d] got %h want %h", k, sum, es); end
         checks++; if (n !== ((k == 0) ? LAT + 2 : LAT + 3)) begin errors++; $display("FAIL fair_tenure[%0d] got %0d want %0d", k, n, (k == 0) ? LAT + 2 : LAT + 3); end
         req = req & ~vld;
      end
      req = '0;
      @(posedge clk);
      #1;
      model_ptr = 0;
   endtask

   task automatic test_wrap();
      logic [W-1:0] a0, b0, a3, b3, es;
      int           n;
      logic [N-1:0] vld;
      logic [W-1:0] sum;
      a0 = W'($urandom); b0 = W'($urandom);
      a3 = W'($urandom); b3 = W'($urandom);
      set_ops(0, a0, b0);
      set_ops(3, a3, b3);
      req = 4'b1001;
      wait_rsp(n, vld, sum);
      exp_rsp++;
      es = a0 + b0;
      checks++; if (vld !== 4'b0001) begin errors++; $display("FAIL wrap_first got %b want 0001", vld); end
      checks++; if (sum !== es) begin errors++; $display("FAIL wrap_first_sum got %h want %h", sum, es); end
      wait_rsp(n, vld, sum);
      exp_rsp++;
      es = a3 + b3;
      checks++; if (vld !== 4'b1000) begin errors++; $display("FAIL wrap_second got %b want 1000", vld); end
      checks++; if (sum !== es) begin errors++; $display("FAIL wrap_second_sum got %h want %h", sum, es); end
      checks++; if (n !== LAT + 3) begin errors++; $display("FAIL wrap_second_gap got %0d want %0d", n, LAT + 3); end
      req = '0;
      @(posedge clk);
      #1;
      model_ptr = 0;
   endtask

   task automatic test_drop();
      logic [W-1:0] a1, b1, es;
      int           n;
      logic [N-1:0] vld;
      logic [W-1:0] sum;
      a1 = W'($urandom); b1 = W'($urandom);
      set_ops(1, a1, b1);
      req = 4'b0010;
      repeat (5) @(posedge clk);
      #1;
      req = '0;
      wait_rsp(n, vld, sum);
      exp_rsp++;
      es = a1 + b1;
      checks++; if (vld !== 4'b0010) begin errors++; $display("FAIL drop_valid got %b want 0010", vld); end
      checks++; if (sum !== es) begin errors++; $display("FAIL drop_sum got %h want %h", sum, es); end
      checks++; if (n + 5 !== LAT + 2) begin errors++; $display("FAIL drop_latency got %0d want %0d", n + 5, LAT + 2); end
      @(posedge clk);
      #1;
      model_ptr = 2;
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] a2, b2, es;
      int           n;
      int           seen;
      logic [N-1:0] vld;
      logic [W-1:0] sum;
      set_ops(2, W'($urandom), W'($urandom));
      req = 4'b0100;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      req = '0;
      #1;
      checks++; if (gnt !== '0 || busy !== 1'b0 || add_en !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got gnt=%b busy=%b en=%b want 0", gnt, busy, add_en); end
      checks++; if (add_a !== '0 || add_b !== '0 || rsp_sum !== '0 || rsp_valid !== '0) begin errors++; $display("FAIL midrst_data got a=%h b=%h sum=%h v=%b want 0", add_a, add_b, rsp_sum, rsp_valid); end
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (i == 1) rst = 1'b0;
         if (rsp_valid != '0) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_rsp got %0d pulses want 0", seen); end
      a2 = W'($urandom); b2 = W'($urandom);
      set_ops(2, a2, b2);
      req = 4'b0100;
      wait_rsp(n, vld, sum);
      exp_rsp++;
      es = a2 + b2;
      checks++; if (vld !== 4'b0100 || n !== LAT + 2) begin errors++; $display("FAIL midrst_after got v=%b n=%0d want 0100 n=%0d", vld, n, LAT + 2); end
      checks++; if (sum !== es) begin errors++; $display("FAIL midrst_after_sum got %h want %h", sum, es); end
      req = '0;
      @(posedge clk);
      #1;
      model_ptr = 3;
   endtask

   task automatic test_random();
      logic [W-1:0] ta [N];
      logic [W-1:0] tb [N];
      logic [N-1:0] pending;
      logic [W-1:0] es;
      int           e;
      int           first;
      int           n;
      logic [N-1:0] vld;
      logic [W-1:0] sum;
      for (int batch = 0; batch < 10; batch++) begin
         pending = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) begin
            ta[i] = W'($urandom);
            tb[i] = W'($urandom);
            set_ops(i, ta[i], tb[i]);
         end
         req = pending;
         first = 1;
         while (pending != '0) begin
            e = -1;
            for (int k = 0; k < N; k++) begin
               if (e < 0 && pending[(model_ptr + k) % N]) e = (model_ptr + k) % N;
            end
            wait_rsp(n, vld, sum);
            exp_rsp++;
            es = ta[e] + tb[e];
            checks++; if (vld !== N'(1 << e)) begin errors++; $display("FAIL rand_pick b%0d got %b want %b", batch, vld, N'(1 << e)); end
            checks++; if (sum !== es) begin errors++; $display("FAIL rand_sum b%0d got %h want %h", batch, sum, es); end
            checks++; if (n !== ((first != 0) ? LAT + 2 : LAT + 3)) begin errors++; $display("FAIL rand_gap b%0d got %0d want %0d", batch, n, (first != 0) ? LAT + 2 : LAT + 3); end
            req = req & ~vld;
            pending[e] = 1'b0;
            model_ptr = (e + 1) % N;
            first = 0;
         end
         if (req != '0) begin
            req = '0;
            repeat (2 * (LAT + 3)) @(posedge clk);
            #1;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_protocol();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (mon_err !== 0) begin errors++; $display("FAIL protocol_violations got %0d want 0", mon_err); end
      checks++; if (adder_err !== 0) begin errors++; $display("FAIL adder_en_while_busy got %0d want 0", adder_err); end
      checks++; if (rsp_cnt !== exp_rsp) begin errors++; $display("FAIL rsp_count got %0d want %0d", rsp_cnt, exp_rsp); end
      checks++; if (en_total !== 2 * exp_rsp + 1) begin errors++; $display("FAIL add_en_count got %0d want %0d", en_total, 2 * exp_rsp + 1); end
   endtask

   initial begin
      rst  = 1'b1;
      req  = '0;
      a_in = '0;
      b_in = '0;
      test_reset();
      test_single();
      test_overflow();
      test_fairness();
      test_wrap();
      test_drop();
      test_reset_mid();
      test_random();
      test_protocol();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/add_serial_arb.md
Name: add_serial_arb

Overview:
- Round-robin arbiter and sequencer that shares one bit-serial adder (8-bit, en/a/b/out interface) among N requesters.
- Grants one requester at a time and presents its operands to the adder.
- Pulses the adder's en to start the add, then waits the adder's fixed latency and captures the sum.
- Pulses en again to return the adder from DONE to IDLE, then returns the sum to the requester.
- Sits between client logic and the adder instance. The adder uses the same clk and rst.

Parameters:
- N, 4, number of requesters (2..8)
- W, 8, operand/sum width; must match the adder
- ADD_LAT, 9, number of WAIT cycles: cycles after the edge that samples add_en until add_out holds the final sum

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N  per-requester request; level, held until its rsp_valid
- a_in  in  N*W  requester i operand A at bits [i*W +: W]; stable while req[i] is high
- b_in  in  N*W  requester i operand B, packed the same way
- gnt  out  N  one-hot; current owner, high from START through RELEASE
- rsp_valid  out  N  one-cycle pulse to the owner when rsp_sum is valid
- rsp_sum  out  W  captured sum (A+B) mod 2^W
- busy  out  1  high in any state other than IDLE
- add_en  out  1  to adder en
- add_a  out  W  to adder a, registered
- add_b  out  W  to adder b, registered
- add_out  in  W  from adder out

Behaviour:
- Reset (async): state=IDLE, ptr=0, owner=0, cnt=0. All outputs are 0: gnt, rsp_valid, rsp_sum, busy, add_en, add_a, add_b.
- FSM states, encoded 2 bits: IDLE=0, START=1, WAIT=2, RELEASE=3.
- IDLE:
  - If req!=0, pick the first set bit scanning ptr, ptr+1, ... mod N.
  - Register owner, add_a=a_in[owner], add_b=b_in[owner], cnt=ADD_LAT-1, then go to START.
  - If req==0, stay in IDLE.
- START: add_en=1 for exactly this cycle; next state WAIT.
- WAIT:
  - cnt decrements each cycle.
  - When cnt==0, rsp_sum<=add_out and the next state is RELEASE.
- RELEASE:
  - add_en=1 (adder DONE->IDLE) and rsp_valid[owner]=1.
  - ptr<=(owner+1) mod N; next state IDLE.
- Outputs:
  - add_en is a Moore decode (START or RELEASE) and must be glitch-free.
  - gnt[owner]=1 in START, WAIT and RELEASE.
- Latency:
  - req sampled in IDLE to rsp_valid is ADD_LAT+2 cycles.
  - Adder occupancy per transaction is ADD_LAT+3 cycles including the IDLE arbitration cycle.
- The transaction is non-abortable. Dropping req[owner] mid-transaction has no effect, and rsp_valid still pulses.
- Requests arriving while busy wait in IDLE arbitration; there is no queueing.
- A requester that keeps req high after its rsp_valid is re-arbitrated behind the others because ptr has advanced.
- The sum is (A+B) mod 2^W; the carry-out is discarded.
- add_a and add_b hold their values until the next grant.
- rsp_sum holds its value until the next capture.
- Reset mid-transaction: immediate return to the reset values. No rsp_valid is issued and the adder is reset by the same rst.

Decomposition:
- Package add_serial_arb_pkg holds:
  - state encoding constants IDLE, START, WAIT, RELEASE
  - default ADD_LAT
  - index width $clog2(N)
- Sub-module rr_pick: combinational round-robin priority picker. Inputs are req[N] and ptr; outputs are a one-hot grant and an index.

Test Plan:
- Single request: req=4'b0001, a0=8'h05, b0=8'h03 -> add_en pulses 1 cycle after grant, rsp_valid[0] 11 cycles after req sampled, rsp_sum=8'h08, busy low afterwards.
- Overflow: requester 2 with a=8'hFF, b=8'h01 -> rsp_sum=8'h00; a=8'hA5, b=8'h5A -> 8'hFF.
- Fairness: req=4'b1111 held, each requester deasserting after its response -> grant order 0,1,2,3, each tenure 12 cycles, gnt always one-hot.
- Pointer wrap: after requester 3 completes, req=4'b1001 -> requester 0 granted next. With ptr=1 and req=4'b1001 -> requester 3 granted.
- Drop and reset: req[1] deasserted during WAIT -> rsp_valid[1] still pulses with the correct sum. Separately, rst asserted during WAIT -> all outputs 0 immediately and no rsp_valid. After release, a new req=4'b0100 completes normally.
- add_en protocol: exactly two add_en pulses per transaction (START, RELEASE), never on consecutive cycles, and add_a/add_b stable from START through RELEASE.
